// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and constants, including the line-fill bridge state
// encoding and the default memory beat width.
package sargantana_icache_pkg;

  localparam int PHY_ADDR_SIZE       = 40;
  localparam int SET_WIDHT           = 512;
  localparam int ICACHE_OFFSET_WIDTH = 6;
  localparam int ICACHE_INDEX_WIDTH  = 12;
  localparam int ICACHE_N_WAY        = 4;
  localparam int IFILL_BEAT_WIDTH    = 128;

  typedef struct packed {
    logic                     valid;
    logic [ICACHE_N_WAY-1:0]  way;
    logic [PHY_ADDR_SIZE-1:0] paddr;
  } ifill_req_o_t;

  typedef struct packed {
    logic                          valid;
    logic [ICACHE_INDEX_WIDTH-1:0] paddr;
  } inv_t;

  typedef struct packed {
    logic                 valid;
    logic                 ack;
    logic [SET_WIDHT-1:0] data;
    inv_t                 inv;
  } ifill_resp_i_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } ifill_state_t;

  // Clear the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [PHY_ADDR_SIZE-1:0] line_align(input logic [PHY_ADDR_SIZE-1:0] paddr);
    return {paddr[PHY_ADDR_SIZE-1:ICACHE_OFFSET_WIDTH], {ICACHE_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_ifill_bridge.sv
// Bridges an icache miss to a beat-wise memory line read and returns the
// assembled line. Define ICACHE_IFILL_INV_FWD_EN to forward invalidations.
module icache_ifill_bridge
  import sargantana_icache_pkg::*;
#(
  parameter int BEAT_WIDTH = IFILL_BEAT_WIDTH,
  parameter int N_BEATS    = SET_WIDHT / BEAT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  ifill_req_o_t                  ifill_req_i,
  output ifill_resp_i_t                 ifill_resp_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PHY_ADDR_SIZE-1:0]      mem_req_addr_o,
  input  logic                          mem_resp_valid_i,
  input  logic [BEAT_WIDTH-1:0]         mem_resp_data_i,
  input  logic                          inv_valid_i,
  input  logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr_i,
  output logic                          busy_o
);

  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  ifill_state_t             state_reg, state_next;
  logic [CNT_W-1:0]         beat_cnt_reg;
  logic [PHY_ADDR_SIZE-1:0] addr_reg;
  logic [BEAT_WIDTH-1:0]    beat_reg [N_BEATS];
  logic [SET_WIDHT-1:0]     line;
  inv_t                     inv_reg;
  logic                     req_take;
  logic                     beat_take;
  logic                     unused_bits;

  assign req_take  = (state_reg == IDLE) && ifill_req_i.valid;
  assign beat_take = (state_reg == FILL) && mem_resp_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ifill_req_i.valid) state_next = REQ;
      REQ:     if (mem_req_ready_i) state_next = FILL;
      FILL:    if (mem_resp_valid_i && beat_cnt_reg == LAST_BEAT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter saturates on the last beat; the FSM leaves FILL on that beat anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_reg <= '0;
      addr_reg     <= '0;
    end else begin
      if (req_take) addr_reg <= line_align(ifill_req_i.paddr);
      if (state_reg == REQ && mem_req_ready_i) beat_cnt_reg <= '0;
      else if (beat_take && beat_cnt_reg != LAST_BEAT) beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
      always_ff @(posedge clk_i) begin
        if (rst_i) beat_reg[gi] <= '0;
        else if (beat_take && beat_cnt_reg == CNT_W'(gi)) beat_reg[gi] <= mem_resp_data_i;
      end
      assign line[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat_reg[gi];
    end
  endgenerate

`ifdef ICACHE_IFILL_INV_FWD_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) inv_reg <= '0;
    else       inv_reg <= '{valid: inv_valid_i, paddr: inv_paddr_i};
  end
  assign unused_bits = ^{ifill_req_i.way, ifill_req_i.paddr[ICACHE_OFFSET_WIDTH-1:0]};
`else
  assign inv_reg     = '0;
  assign unused_bits = ^{ifill_req_i.way, ifill_req_i.paddr[ICACHE_OFFSET_WIDTH-1:0],
                         inv_valid_i, inv_paddr_i};
`endif

  // Strobes are masked by reset so nothing escapes during the reset cycle itself.
  always_comb begin
    ifill_resp_o           = '0;
    ifill_resp_o.data      = line;
    ifill_resp_o.inv.paddr = inv_reg.paddr;
    ifill_resp_o.inv.valid = inv_reg.valid & ~rst_i;
    ifill_resp_o.ack       = req_take & ~rst_i;
    ifill_resp_o.valid     = (state_reg == RESP) & ~rst_i;
    mem_req_valid_o        = (state_reg == REQ) & ~rst_i;
    busy_o                 = (state_reg != IDLE) & ~rst_i;
  end

  assign mem_req_addr_o = addr_reg;

endmodule

// File: tb/tb_icache_ifill_bridge.sv
// Self-checking bench for icache_ifill_bridge: a transaction-level reference
// model compared every cycle, plus literal checks on the directed scenarios.
module tb_icache_ifill_bridge;
  import sargantana_icache_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  ifill_req_o_t                  req;
  ifill_resp_i_t                 resp;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [PHY_ADDR_SIZE-1:0]      mem_req_addr;
  logic                          mem_resp_valid;
  logic [127:0]                  mem_resp_data;
  logic                          inv_valid;
  logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr;
  logic                          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  bit cmp_en  = 1'b0;

  icache_ifill_bridge dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifill_req_i      (req),
    .ifill_resp_o     (resp),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data),
    .inv_valid_i      (inv_valid),
    .inv_paddr_i      (inv_paddr),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: 0 = waiting for a miss, 1 = address offered to memory,
  // 2 = collecting beats, 3 = delivering the line.
  int           m_phase = 0;
  logic [39:0]  m_addr  = '0;
  logic [127:0] m_beats [$];
  logic [511:0] m_data  = '0;
  logic         m_inv_v = 1'b0;
  logic [11:0]  m_inv_p = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_data  = '0;
      m_beats.delete();
      m_inv_v = 1'b0;
      m_inv_p = '0;
    end else begin
`ifdef ICACHE_IFILL_INV_FWD_EN
      m_inv_v = inv_valid;
      m_inv_p = inv_paddr;
`endif
      case (m_phase)
        0: if (req.valid) begin
             m_addr  = (req.paddr / 64) * 64;
             m_phase = 1;
           end
        1: if (mem_req_ready) begin
             m_beats.delete();
             m_phase = 2;
           end
        2: if (mem_resp_valid) begin
             m_beats.push_back(mem_resp_data);
             if (m_beats.size() == 4) begin
               m_data = '0;
               for (int i = 0; i < 4; i++) m_data = m_data | (512'(m_beats[i]) << (128 * i));
               m_phase = 3;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("ack", resp.ack, !rst && m_phase == 0 && req.valid);
      chk("mem_req_valid", mem_req_valid, !rst && m_phase == 1);
      if (!rst && m_phase == 1) chk("mem_req_addr", mem_req_addr, m_addr);
      chk("busy", busy, !rst && m_phase != 0);
      chk("resp_valid", resp.valid, !rst && m_phase == 3);
      if (!rst && m_phase != 2) chk("resp_data", resp.data, m_data);
`ifdef ICACHE_IFILL_INV_FWD_EN
      chk("inv_valid", resp.inv.valid, !rst && m_inv_v);
      if (!rst) chk("inv_paddr", resp.inv.paddr, m_inv_p);
`else
      chk("inv_valid", resp.inv.valid, 1'b0);
      chk("inv_paddr", resp.inv.paddr, 12'h0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic fill(input logic [39:0] pa, input logic [31:0] seed, input int gap);
    $display("[TB] fill paddr=%h seed=%h gap=%0d", pa, seed, gap);
    req.valid = 1'b1;
    req.paddr = pa;
    cyc();
    req.valid     = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{seed + 32'(k)}};
      cyc();
      mem_resp_valid = 1'b0;
      if (k < 3) repeat (gap) cyc();
    end
    cyc();
  endtask

  logic [127:0] b_a, b_d;
  int t0, t1;
  bit got;

  initial begin
    rst = 1'b1;
    req = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    inv_valid = 1'b0;
    inv_paddr = '0;
    b_a = {32{4'hA}};
    b_d = {32{4'hD}};
    cyc();
    cmp_en = 1'b1;
    cyc();
    rst = 1'b0;
    at_neg();
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", resp.data, 512'h0);
    cyc();

    // Basic fill with an invalidation alongside the last beat
    $display("[TB] basic fill paddr=8000_1234");
    req.valid = 1'b1;
    req.paddr = 40'h80001234;
    req.way   = 4'b0010;
    at_neg();
    chk("t1_ack", resp.ack, 1'b1);
    cyc();
    req.valid     = 1'b0;
    mem_req_ready = 1'b1;
    at_neg();
    chk("t1_addr", mem_req_addr, 40'h80001200);
    chk("t1_mreq_valid", mem_req_valid, 1'b1);
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {32{4'(4'hA + k)}};
      if (k == 3) begin
        inv_valid = 1'b1;
        inv_paddr = 12'h2C0;
      end
      cyc();
    end
    mem_resp_valid = 1'b0;
    inv_valid      = 1'b0;
    at_neg();
    chk("t1_resp_valid", resp.valid, 1'b1);
    chk("t1_data_lo", resp.data[127:0], b_a);
    chk("t1_data_hi", resp.data[511:384], b_d);
`ifdef ICACHE_IFILL_INV_FWD_EN
    chk("t1_inv_valid", resp.inv.valid, 1'b1);
    chk("t1_inv_paddr", resp.inv.paddr, 12'h2C0);
`else
    chk("t1_inv_off", resp.inv.valid, 1'b0);
`endif
    cyc();
    at_neg();
    chk("t1_resp_pulse", resp.valid, 1'b0);
    cyc();

    // Backpressure: ready low 5 cycles, request held high to probe no re-ack
    $display("[TB] backpressure paddr=0000_4567");
    req.valid = 1'b1;
    req.paddr = 40'h0000004567;
    cyc();
    req.paddr = 40'h00000ABCDE;
    repeat (5) cyc();
    at_neg();
    chk("t2_addr_hold", mem_req_addr, 40'h0000004540);
    chk("t2_no_reack", resp.ack, 1'b0);
    req.valid     = 1'b0;
    cyc();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'h11110000 + 32'(k)}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    cyc();

    // Gapped beats
    fill(40'h00DEADBEEF, 32'h5A5A0000, 2);

    // Back-to-back: second request held during the first fill
    $display("[TB] back-to-back paddr=0000_1000 then 0000_2040");
    req.valid = 1'b1;
    req.paddr = 40'h0000001000;
    at_neg();
    t0 = cyc_n;
    cyc();
    req.paddr      = 40'h0000002040;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hBAD0BAD0}};
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'h77770000 + 32'(k)}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      at_neg();
      if (resp.ack) got = 1'b1;
      else cyc();
    end
    t1 = cyc_n;
    chk("t4_ack2_seen", got, 1'b1);
    chk("t4_ack_spacing", t1 - t0, 7);
    cyc();
    req.valid     = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'h88880000 + 32'(k)}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    cyc();
    $display("[TB] stray beats in idle");
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hDEADDEAD}};
    repeat (2) cyc();
    mem_resp_valid = 1'b0;
    at_neg();
    chk("t4_stray_hi", resp.data[511:384], {4{32'h88880003}});
    cyc();

    // Reset after beat 2
    $display("[TB] reset mid-fill paddr=0000_3000");
    req.valid = 1'b1;
    req.paddr = 40'h0000003000;
    cyc();
    req.valid     = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'h99990000 + 32'(k)}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    at_neg();
    chk("t5_busy", busy, 1'b0);
    chk("t5_no_resp", resp.valid, 1'b0);
    for (int k = 2; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'h99990000 + 32'(k)}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    at_neg();
    chk("t5_data_cleared", resp.data, 512'h0);
    cyc();
    fill(40'h0000003000, 32'hC0DE0000, 0);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
